// File: rtl/regfl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | regfl_pkg : shared types and default widths for the regfl read side  |
// | Revision  : 1.0                                                      |
// +----------------------------------------------------------------------+
package regfl_pkg;

    localparam int REG_W   = 64;
    localparam int REG_CNT = 8;
    localparam int DEC_W   = 3;
    localparam int LEN_W   = 4;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/regfl_rd_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | regfl_rd_if : request and beat channels of the burst read engine     |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
interface regfl_rd_if
    import regfl_pkg::*;
#(
    parameter int REG_W_P = REG_W,
    parameter int DEC_W_P = DEC_W,
    parameter int LEN_W_P = LEN_W
);
    logic               req_vld;
    logic               req_rdy;
    logic [DEC_W_P-1:0] req_addr;
    logic [LEN_W_P-1:0] req_len;

    logic               out_vld;
    logic               out_rdy;
    logic [REG_W_P-1:0] out_data;
    logic [DEC_W_P-1:0] out_idx;
    logic               out_last;

    modport master (
        output req_vld, req_addr, req_len, out_rdy,
        input  req_rdy, out_vld, out_data, out_idx, out_last
    );

    modport slave (
        input  req_vld, req_addr, req_len, out_rdy,
        output req_rdy, out_vld, out_data, out_idx, out_last
    );
endinterface
`default_nettype wire

// File: rtl/regfl_wsel.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | regfl_wsel : combinational word selector over the flat q bus         |
// | Revision   : 1.0                                                     |
// +----------------------------------------------------------------------+
module regfl_wsel
    import regfl_pkg::*;
#(
    parameter int REG_W_P   = REG_W,
    parameter int REG_CNT_P = REG_CNT,
    parameter int DEC_W_P   = DEC_W
) (
    input  wire logic [REG_CNT_P*REG_W_P-1:0] q_in,
    input  wire logic [DEC_W_P-1:0]           idx,
    output      logic [REG_W_P-1:0]           word
);
    logic [REG_W_P-1:0] w_words [REG_CNT_P];

    for (genvar gi = 0; gi < REG_CNT_P; gi++) begin : g_words
        assign w_words[gi] = q_in[gi*REG_W_P +: REG_W_P];
    end

    assign word = w_words[idx];
endmodule
`default_nettype wire

// File: rtl/regfl_rd.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | regfl_rd : burst read engine streaming register words one per cycle  |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module regfl_rd
    import regfl_pkg::*;
#(
    parameter int REG_W_P   = REG_W,
    parameter int REG_CNT_P = REG_CNT,
    parameter int DEC_W_P   = DEC_W,
    parameter int LEN_W_P   = LEN_W
) (
    input  wire logic                         clk,
    input  wire logic                         rst,
    input  wire logic [REG_CNT_P*REG_W_P-1:0] q_in,
    output      logic                         busy,
    regfl_rd_if.slave                         bus
);
    state_t               r_state;
    logic [DEC_W_P-1:0]   r_ptr;
    logic [LEN_W_P-1:0]   r_cnt;
    logic                 r_vld;
    logic [REG_W_P-1:0]   r_data;
    logic [DEC_W_P-1:0]   r_idx;
    logic                 r_last;

    logic [DEC_W_P-1:0]   w_nxt_ptr;
    logic [REG_W_P-1:0]   w_word;

    // The selector always looks at the index about to be loaded, so the
    // word is captured on the same edge that advances the pointer.
    assign w_nxt_ptr = (r_state == IDLE) ? bus.req_addr : r_ptr + DEC_W_P'(1);

    regfl_wsel #(
        .REG_W_P   (REG_W_P),
        .REG_CNT_P (REG_CNT_P),
        .DEC_W_P   (DEC_W_P)
    ) u_wsel (
        .q_in (q_in),
        .idx  (w_nxt_ptr),
        .word (w_word)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_cnt   <= '0;
            r_vld   <= 1'b0;
            r_data  <= '0;
            r_idx   <= '0;
            r_last  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.req_vld) begin
                        r_ptr   <= w_nxt_ptr;
                        r_cnt   <= bus.req_len;
                        r_data  <= w_word;
                        r_idx   <= w_nxt_ptr;
                        r_last  <= (bus.req_len == '0);
                        r_vld   <= 1'b1;
                        r_state <= SEND;
                    end
                end
                SEND: begin
                    if (r_vld && bus.out_rdy) begin
                        if (r_cnt == '0) begin
                            r_vld   <= 1'b0;
                            r_last  <= 1'b0;
                            r_state <= IDLE;
                        end else begin
                            r_ptr  <= w_nxt_ptr;
                            r_cnt  <= r_cnt - LEN_W_P'(1);
                            r_data <= w_word;
                            r_idx  <= w_nxt_ptr;
                            r_last <= (r_cnt == LEN_W_P'(1));
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Ready drops combinationally with rst so nothing is accepted during reset.
    assign bus.req_rdy  = (r_state == IDLE) & ~rst;
    assign bus.out_vld  = r_vld;
    assign bus.out_data = r_data;
    assign bus.out_idx  = r_idx;
    assign bus.out_last = r_last;
    assign busy         = (r_state == SEND);
endmodule
`default_nettype wire

// File: tb/tb_regfl_rd.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_regfl_rd : directed vector bench for the register file read engine |
// | Revision    : 1.0                                                     |
// +----------------------------------------------------------------------+
module tb_regfl_rd;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [511:0] q_in;
    logic         busy;

    logic [63:0]  regs [8];
    logic         wr_en = 1'b0;
    logic [2:0]   wr_idx = '0;
    logic [63:0]  wr_data = '0;

    int pass_cnt = 0;
    int total_cnt = 0;

    regfl_rd_if bus ();

    regfl_rd dut (
        .clk  (clk),
        .rst  (rst),
        .q_in (q_in),
        .busy (busy),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    // Register file model: writes land on the clock edge.
    always @(posedge clk) begin
        if (wr_en) regs[wr_idx] <= wr_data;
    end

    for (genvar g = 0; g < 8; g++) begin : g_q
        assign q_in[g*64 +: 64] = regs[g];
    end

    typedef struct {
        logic [2:0] addr;
        logic [3:0] len;
        logic [2:0] exp_last_idx;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        else
            pass_cnt++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] i, input logic [63:0] d);
        wr_en = 1'b1; wr_idx = i; wr_data = d;
        step();
        wr_en = 1'b0;
    endtask

    task automatic run_burst(input logic [2:0] a, input logic [3:0] l,
                             input int stall_beat, input int stall_cyc,
                             output logic [2:0] last_idx);
        logic [2:0] ei;
        check("req_rdy_idle", 64'(bus.req_rdy), 64'd1);
        bus.req_vld = 1'b1; bus.req_addr = a; bus.req_len = l;
        step();
        bus.req_vld = 1'b0;
        check("busy_send", 64'(busy), 64'd1);
        check("req_rdy_send", 64'(bus.req_rdy), 64'd0);
        last_idx = '0;
        for (int k = 0; k <= int'(l); k++) begin
            ei = a + 3'(k);
            check("beat_vld", 64'(bus.out_vld), 64'd1);
            check("beat_idx", 64'(bus.out_idx), 64'(ei));
            check("beat_data", bus.out_data, regs[ei]);
            check("beat_last", 64'(bus.out_last), 64'(k == int'(l)));
            if (k == stall_beat) begin
                bus.out_rdy = 1'b0;
                for (int s = 0; s < stall_cyc; s++) begin
                    step();
                    check("hold_vld", 64'(bus.out_vld), 64'd1);
                    check("hold_idx", 64'(bus.out_idx), 64'(ei));
                    check("hold_data", bus.out_data, regs[ei]);
                end
                bus.out_rdy = 1'b1;
            end
            last_idx = bus.out_idx;
            step();
        end
        check("end_vld", 64'(bus.out_vld), 64'd0);
        check("end_busy", 64'(busy), 64'd0);
        check("end_req_rdy", 64'(bus.req_rdy), 64'd1);
    endtask

    initial begin
        logic [2:0] li;
        bus.req_vld = 1'b0; bus.req_addr = '0; bus.req_len = '0; bus.out_rdy = 1'b1;

        vecs[0] = '{addr: 3'd6, len: 4'd3,  exp_last_idx: 3'd1};
        vecs[1] = '{addr: 3'd0, len: 4'd0,  exp_last_idx: 3'd0};
        vecs[2] = '{addr: 3'd7, len: 4'd0,  exp_last_idx: 3'd7};
        vecs[3] = '{addr: 3'd2, len: 4'd7,  exp_last_idx: 3'd1};
        vecs[4] = '{addr: 3'd5, len: 4'd15, exp_last_idx: 3'd4};
        vecs[5] = '{addr: 3'd0, len: 4'd7,  exp_last_idx: 3'd7};

        for (int i = 0; i < 8; i++) wr(3'(i), 64'h100 + 64'(i));

        check("rst_req_rdy", 64'(bus.req_rdy), 64'd0);
        check("rst_vld", 64'(bus.out_vld), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_data", bus.out_data, 64'd0);
        check("rst_idx", 64'(bus.out_idx), 64'd0);
        check("rst_last", 64'(bus.out_last), 64'd0);
        rst = 1'b0;
        step();
        check("post_rst_req_rdy", 64'(bus.req_rdy), 64'd1);

        // Single beat
        wr(3'd3, 64'hDEAD_BEEF);
        bus.req_vld = 1'b1; bus.req_addr = 3'd3; bus.req_len = 4'd0;
        step();
        bus.req_vld = 1'b0;
        check("single_vld", 64'(bus.out_vld), 64'd1);
        check("single_data", bus.out_data, 64'hDEAD_BEEF);
        check("single_idx", 64'(bus.out_idx), 64'd3);
        check("single_last", 64'(bus.out_last), 64'd1);
        step();
        check("single_idle", 64'(busy), 64'd0);
        check("single_vld_off", 64'(bus.out_vld), 64'd0);
        wr(3'd3, 64'h103);

        for (int v = 0; v < 6; v++) begin
            run_burst(vecs[v].addr, vecs[v].len, -1, 0, li);
            check("vec_last_idx", 64'(li), 64'(vecs[v].exp_last_idx));
        end

        // Backpressure on beat 2 of the wrap burst
        run_burst(3'd6, 4'd3, 1, 3, li);
        check("bp_last_idx", 64'(li), 64'd1);

        // Sample point: reg1 write lands on the edge loading beat idx 1
        bus.req_vld = 1'b1; bus.req_addr = 3'd0; bus.req_len = 4'd2;
        step();
        bus.req_vld = 1'b0;
        check("sp_idx0", 64'(bus.out_idx), 64'd0);
        wr_en = 1'b1; wr_idx = 3'd1; wr_data = 64'hAA;
        step();
        wr_en = 1'b0;
        check("sp_idx1", 64'(bus.out_idx), 64'd1);
        check("sp_old_data", bus.out_data, 64'h101);
        step();
        check("sp_idx2", 64'(bus.out_idx), 64'd2);
        check("sp_last", 64'(bus.out_last), 64'd1);
        step();
        check("sp_done", 64'(bus.out_vld), 64'd0);
        bus.req_vld = 1'b1; bus.req_addr = 3'd1; bus.req_len = 4'd0;
        step();
        bus.req_vld = 1'b0;
        check("sp_new_data", bus.out_data, 64'hAA);
        step();
        wr(3'd1, 64'h101);

        // Overlap: second request held during SEND
        bus.req_vld = 1'b1; bus.req_addr = 3'd4; bus.req_len = 4'd2;
        step();
        bus.req_addr = 3'd0; bus.req_len = 4'd0;
        for (int k = 0; k < 3; k++) begin
            check("ov_req_rdy_low", 64'(bus.req_rdy), 64'd0);
            check("ov_idx", 64'(bus.out_idx), 64'(4 + k));
            step();
        end
        check("ov_req_rdy_back", 64'(bus.req_rdy), 64'd1);
        check("ov_gap_vld", 64'(bus.out_vld), 64'd0);
        step();
        bus.req_vld = 1'b0;
        check("ov2_vld", 64'(bus.out_vld), 64'd1);
        check("ov2_idx", 64'(bus.out_idx), 64'd0);
        check("ov2_data", bus.out_data, 64'h100);
        check("ov2_last", 64'(bus.out_last), 64'd1);
        step();
        check("ov2_done", 64'(bus.out_vld), 64'd0);

        // Reset mid-burst on beat 2 of 8
        bus.req_vld = 1'b1; bus.req_addr = 3'd0; bus.req_len = 4'd7;
        step();
        bus.req_vld = 1'b0;
        step();
        check("mr_idx1", 64'(bus.out_idx), 64'd1);
        #2 rst = 1'b1;
        #1;
        check("mr_vld", 64'(bus.out_vld), 64'd0);
        check("mr_data", bus.out_data, 64'd0);
        check("mr_busy", 64'(busy), 64'd0);
        check("mr_req_rdy", 64'(bus.req_rdy), 64'd0);
        step();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            check("mr_no_beats", 64'(bus.out_vld), 64'd0);
            check("mr_idle", 64'(busy), 64'd0);
        end
        check("mr_req_rdy_back", 64'(bus.req_rdy), 64'd1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
`default_nettype wire
